tt_ctrl_seq: RTL and testbench
==============================

TT_CTRL_SEQ -- requirements
Module: tt_ctrl_seq

Interface
REQ-001 Parameter ADDR_W, 10, width of design-select address; SHALL match the mux select counter width.
REQ-002 Parameter PULSE_W, 2, cycles per ctrl_sel_inc high phase, low phase and disable guard; SHALL be >=1.
REQ-003 Parameter RST_W, 4, cycles ctrl_sel_rst_n is held low per select reset; SHALL be >=1.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 req_valid  in  1  select request strobe.
REQ-007 req_addr  in  ADDR_W  target design address.
REQ-008 req_ena  in  1  drive ctrl_ena high after selection (0 = select but leave disabled).
REQ-009 req_ready  out  1  high only in IDLE; request accepted on req_valid && req_ready.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 done  out  1  one-cycle pulse on sequence completion.
REQ-012 cur_addr  out  ADDR_W  shadow of the mux select counter value.
REQ-013 ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena  out  1 each  registered drives to the mux controller inputs.

Function
REQ-014 FSM states IDLE, DIS, RST, INC_H, INC_L, FIN; all outputs SHALL be registered, glitch-free.
REQ-015 IDLE: req_ready=1, ctrl_sel_rst_n=1, ctrl_sel_inc=0, ctrl_ena holds last value; on accept latch req_addr/req_ena -> DIS.
REQ-016 req_valid outside IDLE SHALL be ignored (not queued, not latched).
REQ-017 DIS: ctrl_ena=0 for exactly PULSE_W cycles; then path decision per REQ-024/REQ-025.
REQ-018 RST: ctrl_sel_rst_n=0 for exactly RST_W cycles; cur_addr<=0; remaining<=target; exit -> INC_H if remaining!=0 else FIN.
REQ-019 INC_H: ctrl_sel_inc=1 for PULSE_W cycles; on entry cur_addr<=cur_addr+1 (mod 2^ADDR_W), remaining<=remaining-1; -> INC_L.
REQ-020 INC_L: ctrl_sel_inc=0 for PULSE_W cycles; -> INC_H if remaining!=0 else FIN.
REQ-021 FIN: one cycle; done=1; ctrl_ena=latched req_ena; -> IDLE; ctrl_ena holds thereafter.
REQ-022 Timing, acceptance edge = cycle 0, reset path, address A: DIS cycles 1..P, RST cycles P+1..P+R, done/ctrl_ena valid at cycle P+R+2*P*A+1 (P=PULSE_W, R=RST_W).
REQ-023 ctrl_ena SHALL never be high while ctrl_sel_rst_n=0 or ctrl_sel_inc toggles.
REQ-024 Reset path (always used when feature of REQ-029 absent): DIS -> RST, counting A pulses from 0.
REQ-025 Incremental path (REQ-029): if req_addr >= cur_addr, DIS -> INC_H with remaining=req_addr-cur_addr, or -> FIN if equal; else reset path.
REQ-026 req_addr equal to 0 on reset path SHALL yield RST then FIN with zero inc pulses.

Reset
REQ-027 While rst=1 at a clock edge: state=IDLE, ctrl_sel_rst_n=0, ctrl_sel_inc=0, ctrl_ena=0, done=0, busy=0, req_ready=0, cur_addr=0; first cycle after rst drops: ctrl_sel_rst_n=1, req_ready=1.
REQ-028 rst mid-sequence SHALL abort immediately with REQ-027 values; cur_addr=0 stays consistent since mux counter is cleared by ctrl_sel_rst_n=0.

Configuration
REQ-029 Macro TT_CTRL_SEQ_INCREMENTAL_EN: defined -> REQ-025 path and comparator compiled in; undefined -> every request uses reset path, cur_addr still tracked.

Verification
REQ-030 P=2,R=4, after reset, request addr=5 ena=1 -> 1 RST pulse of 4 cycles, 5 inc pulses (2 high/2 low), done+ctrl_ena=1 at cycle 27, cur_addr=5.
REQ-031 Incremental on, cur_addr=5, request 7 -> no RST, 2 inc pulses, done at cycle 11, cur_addr=7; macro off -> done at cycle 35.
REQ-032 Incremental on, cur_addr=7, request 3 ena=0 -> RST then 3 pulses, done at cycle 19, ctrl_ena=0, cur_addr=3.
REQ-033 Request addr=0 (reset path) -> done at cycle 7, zero inc pulses; request 1023 -> cur_addr=1023, no wrap.
REQ-034 req_valid pulses while busy -> ignored, req_ready=0; rst asserted during INC_H -> next cycle all outputs at REQ-027 values, cur_addr=0.

Source files
------------

// File: rtl/tt_ctrl_seq.sv
// -----------------------------------------------------------------------------
// tt_ctrl_seq
//
// Purpose: sequences the external design-select mux controller. A request names
// a target design address. The block first disables the current design, then
// steps the mux select counter to the target using reset and increment pulses.
// Finally it re-enables the design if the request asked for that. Every output
// is a flop, so the controller inputs never glitch.
//
// Configuration macro: TT_CTRL_SEQ_INCREMENTAL_EN
//   undefined : every request clears the select counter and counts up from 0.
//   defined   : if the target is at or above the current address, the block
//               counts up from where it is and skips the counter reset.
//
// Ports:
//   clk             in   single clock, rising edge
//   rst             in   synchronous, active-high reset
//   req_valid       in   request strobe (only sampled while req_ready=1)
//   req_addr        in   target design address [ADDR_W-1:0]
//   req_ena         in   1 = enable the design after selection
//   req_ready       out  high only while idle
//   busy            out  high in every state except idle
//   done            out  one-cycle pulse when a sequence completes
//   cur_addr        out  shadow copy of the mux select counter [ADDR_W-1:0]
//   ctrl_sel_rst_n  out  mux select counter clear (active low)
//   ctrl_sel_inc    out  mux select counter increment pulse
//   ctrl_ena        out  design enable; holds its value between requests
// -----------------------------------------------------------------------------
module tt_ctrl_seq #(
  parameter int ADDR_W  = 10,
  parameter int PULSE_W = 2,
  parameter int RST_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_ena,
  output logic              req_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              ctrl_sel_rst_n,
  output logic              ctrl_sel_inc,
  output logic              ctrl_ena
);

  // One phase counter serves the DIS, RST, INC_H and INC_L phases.
  localparam int CNT_MAX = (PULSE_W > RST_W) ? PULSE_W : RST_W;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_W - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DIS, S_RST, S_INC_H, S_INC_L, S_FIN
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   target_q, target_d;
  logic                ena_q, ena_d;
  logic [ADDR_W-1:0]   remaining_q, remaining_d;
  logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
  logic                sel_rst_n_q, sel_rst_n_d;
  logic                sel_inc_q, sel_inc_d;
  logic                ctrl_ena_q, ctrl_ena_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                ready_q, ready_d;

  // NOTE: every signal driven here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    target_d    = target_q;
    ena_d       = ena_q;
    remaining_d = remaining_q;
    cur_addr_d  = cur_addr_q;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        // ready_q is high only in idle, so this is the accept handshake.
        if (req_valid && ready_q) begin
          target_d = req_addr;
          ena_d    = req_ena;
          state_d  = S_DIS;
        end
      end

      S_DIS: begin
        if (cnt_q == PULSE_LAST) begin
          cnt_d = '0;
`ifdef TT_CTRL_SEQ_INCREMENTAL_EN
          if (target_q >= cur_addr_q) begin
            if (target_q == cur_addr_q) begin
              state_d = S_FIN;
            end else begin
              // This is the entry to the first pulse, so one step is taken
              // on the way in.
              state_d     = S_INC_H;
              cur_addr_d  = cur_addr_q + ADDR_W'(1);
              remaining_d = target_q - cur_addr_q - ADDR_W'(1);
            end
          end else begin
            state_d     = S_RST;
            cur_addr_d  = '0;
            remaining_d = target_q;
          end
`else
          state_d     = S_RST;
          cur_addr_d  = '0;
          remaining_d = target_q;
`endif
        end
      end

      S_RST, S_INC_L: begin
        if (cnt_q == ((state_q == S_RST) ? RST_LAST : PULSE_LAST)) begin
          cnt_d = '0;
          if (remaining_q != '0) begin
            // The shadow advances when the increment pulse rises.
            state_d     = S_INC_H;
            cur_addr_d  = cur_addr_q + ADDR_W'(1);
            remaining_d = remaining_q - ADDR_W'(1);
          end else begin
            state_d = S_FIN;
          end
        end
      end

      S_INC_H: begin
        if (cnt_q == PULSE_LAST) begin
          cnt_d   = '0;
          state_d = S_INC_L;
        end
      end

      S_FIN: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end

      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    // The outputs are decoded from the next state and then registered, so
    // they change on the same edge as the state.
    sel_rst_n_d = (state_d != S_RST);
    sel_inc_d   = (state_d == S_INC_H);
    done_d      = (state_d == S_FIN);
    busy_d      = (state_d != S_IDLE);
    ready_d     = (state_d == S_IDLE);
    unique case (state_d)
      S_IDLE:  ctrl_ena_d = ctrl_ena_q;
      S_FIN:   ctrl_ena_d = ena_q;
      default: ctrl_ena_d = 1'b0;
    endcase
  end

  // NOTE: state updates use non-blocking assignments, so every flop samples
  // the values from before the edge and the evaluation order does not matter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      target_q    <= '0;
      ena_q       <= 1'b0;
      remaining_q <= '0;
      cur_addr_q  <= '0;
      sel_rst_n_q <= 1'b0;
      sel_inc_q   <= 1'b0;
      ctrl_ena_q  <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      target_q    <= target_d;
      ena_q       <= ena_d;
      remaining_q <= remaining_d;
      cur_addr_q  <= cur_addr_d;
      sel_rst_n_q <= sel_rst_n_d;
      sel_inc_q   <= sel_inc_d;
      ctrl_ena_q  <= ctrl_ena_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
    end
  end

  assign req_ready      = ready_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign cur_addr       = cur_addr_q;
  assign ctrl_sel_rst_n = sel_rst_n_q;
  assign ctrl_sel_inc   = sel_inc_q;
  assign ctrl_ena       = ctrl_ena_q;

endmodule

// File: tb/tb_tt_ctrl_seq.sv
// -----------------------------------------------------------------------------
// tb_tt_ctrl_seq
//
// Self-checking bench for tt_ctrl_seq with P=2, R=4 and ADDR_W=10. The
// reference model works from the externally visible rules only:
//   - the chosen path (reset or incremental),
//   - the number of pulses and the number of select-reset cycles,
//   - the done cycle, counted from the acceptance edge.
// It then compares these against counts gathered from the DUT outputs.
// -----------------------------------------------------------------------------
module tb_tt_ctrl_seq;

  localparam int ADDR_W = 10;
  localparam int P      = 2;
  localparam int R      = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ena;
  logic              req_ready;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] cur_addr;
  logic              ctrl_sel_rst_n;
  logic              ctrl_sel_inc;
  logic              ctrl_ena;

  int n_cmp = 0;
  int n_mis = 0;
  int model_cur = 0;

  always #5 clk = ~clk;

  tt_ctrl_seq #(.ADDR_W(ADDR_W), .PULSE_W(P), .RST_W(R)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_addr       (req_addr),
    .req_ena        (req_ena),
    .req_ready      (req_ready),
    .busy           (busy),
    .done           (done),
    .cur_addr       (cur_addr),
    .ctrl_sel_rst_n (ctrl_sel_rst_n),
    .ctrl_sel_inc   (ctrl_sel_inc),
    .ctrl_ena       (ctrl_ena)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Issues one request at a negedge and follows it until done. Outputs are
  // sampled on negedges; the k-th negedge after acceptance is cycle k.
  task automatic run_req(input int a, input bit e);
    bit   rpath;
    int   exp_pulses, exp_rst_cyc, exp_done;
    int   done_cyc = -1;
    int   rst_lo = 0, inc_hi = 0, inc_rise = 0, ena_bad = 0, hs_bad = 0;
    logic prev_inc = 1'b0;

    rpath = 1'b1;
`ifdef TT_CTRL_SEQ_INCREMENTAL_EN
    if (a >= model_cur) rpath = 1'b0;
`endif
    exp_pulses  = rpath ? a : a - model_cur;
    exp_rst_cyc = rpath ? R : 0;
    exp_done    = P + exp_rst_cyc + 2 * P * exp_pulses + 1;

    for (int w = 0; w < 10 && req_ready !== 1'b1; w++) @(negedge clk);
    check("ready_before_req", req_ready, 1);

    req_valid = 1'b1;
    req_addr  = ADDR_W'(a);
    req_ena   = e;
    for (int cyc = 1; cyc <= exp_done + 50; cyc++) begin
      @(negedge clk);
      if (ctrl_sel_rst_n === 1'b0) rst_lo++;
      if (ctrl_sel_inc === 1'b1) begin
        inc_hi++;
        if (prev_inc !== 1'b1) inc_rise++;
      end
      prev_inc = ctrl_sel_inc;
      if (ctrl_ena !== 1'b0 && done !== 1'b1) ena_bad++;
      if (req_ready !== 1'b0 || busy !== 1'b1) hs_bad++;
      if (done === 1'b1) begin
        done_cyc  = cyc;
        req_valid = 1'b0;
        break;
      end
      // Noise while busy: these requests must all be ignored.
      req_valid = 1'($urandom);
      req_addr  = ADDR_W'($urandom);
      req_ena   = 1'($urandom);
    end
    req_valid = 1'b0;

    check("done_cycle", done_cyc, exp_done);
    check("cur_addr_at_done", cur_addr, a);
    check("ctrl_ena_at_done", ctrl_ena, e);
    check("sel_rst_low_cycles", rst_lo, exp_rst_cyc);
    check("inc_pulses", inc_rise, exp_pulses);
    check("inc_high_cycles", inc_hi, P * exp_pulses);
    check("ena_while_seq", ena_bad, 0);
    check("ready_busy_while_seq", hs_bad, 0);

    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("idle_busy", busy, 0);
    check("idle_ready", req_ready, 1);
    check("ena_hold", ctrl_ena, e);
    check("cur_addr_hold", cur_addr, a);
    model_cur = a;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_sel_rst_n"}, ctrl_sel_rst_n, 0);
    check({tag, "_inc"}, ctrl_sel_inc, 0);
    check({tag, "_ena"}, ctrl_ena, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ready"}, req_ready, 0);
    check({tag, "_cur_addr"}, cur_addr, 0);
  endtask

  initial begin
    int found;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    req_ena   = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    rst = 1'b0;
    @(negedge clk);
    check("por_release_ready", req_ready, 1);
    check("por_release_sel_rst_n", ctrl_sel_rst_n, 1);
    model_cur = 0;

    // Directed cases from the scenario list.
    run_req(5, 1'b1);
    run_req(7, 1'b1);
    run_req(3, 1'b0);
    run_req(0, 1'b1);
    run_req(1023, 1'b1);

    // Abort with rst while an increment pulse is high.
    req_valid = 1'b1;
    req_addr  = ADDR_W'(10);
    req_ena   = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    found = 0;
    for (int w = 0; w < 200; w++) begin
      if (ctrl_sel_inc === 1'b1) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check("abort_reached_inc_h", found, 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("abort");
    rst = 1'b0;
    @(negedge clk);
    check("abort_release_ready", req_ready, 1);
    check("abort_release_sel_rst_n", ctrl_sel_rst_n, 1);
    model_cur = 0;

    // Randomized requests, some near the current address so both orderings
    // of target and current address are exercised.
    for (int i = 0; i < 12; i++) begin
      int a;
      if ($urandom_range(0, 1) == 0) a = $urandom_range(0, 40);
      else a = (model_cur + $urandom_range(0, 6) + 1023 - 3) % 1024;
      run_req(a, 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
